// File: rtl/mips_16_mem_pkg.sv
// mips_16_mem_pkg
// Shared definitions for the MEM-stage data memory with an external port.
//   ext_state_t : external-access sequencer states
//   ERR_DATA    : fill pattern returned for an external read that times out
//   lane_count  : number of byte lanes in a data word
package mips_16_mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXT_WAIT = 2'd1,
        EXT_DONE = 2'd2
    } ext_state_t;

    // Wide enough for any supported word; users slice the low DATA_WIDTH bits.
    localparam int ERR_DATA_MAX_W = 64;
    localparam logic [ERR_DATA_MAX_W-1:0] ERR_DATA = '1;

    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/mem_bank_be.sv
// mem_bank_be
// Single-port RAM with per-byte write enables and a registered read port.
// The read register only loads on re, so it holds its value between reads.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears the read register only)
//   we, be   : word write strobe and byte-lane enables
//   re       : read strobe; rdata is valid the cycle after
//   addr     : word address
//   wdata    : write data
//   rdata    : registered read data
module mem_bank_be
    import mips_16_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LOCAL_AW   = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               we,
    input  logic                               re,
    input  logic [lane_count(DATA_WIDTH)-1:0]  be,
    input  logic [LOCAL_AW-1:0]                addr,
    input  logic [DATA_WIDTH-1:0]              wdata,
    output logic [DATA_WIDTH-1:0]              rdata
);

    localparam int NB    = lane_count(DATA_WIDTH);
    localparam int DEPTH = 1 << LOCAL_AW;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // No reset on the array so it maps onto block RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_ext.sv
// data_mem_ext
// MEM-stage data memory: a local byte-enabled RAM for the low address range,
// with accesses above it forwarded to an external memory port.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   mem_access_addr     : word address from the pipeline
//   mem_read_en/_write_en : request strobes; write wins when both are set
//   mem_byte_en         : byte-lane write enables (ignored on reads)
//   mem_write_data      : write data
//   mem_read_data       : read data, meaningful while mem_read_valid = 1, held otherwise
//   mem_read_valid      : one-cycle pulse when read data is returned
//   mem_stall           : pipeline must hold its request while high
//   mem_err             : one-cycle pulse when an external access times out
//   ext_req/we/addr/wdata/be : external request and its latched payload
//   ext_ack, ext_rdata  : external completion pulse and read data
//
// External handshake: ext_req rises the cycle after launch with the payload
// already stable, stays high until the cycle in which ext_ack is sampled
// high (or the wait budget runs out), and drops on the following edge.
// ext_rdata is only sampled together with ext_ack; ext_ack seen outside the
// wait state is ignored.
module data_mem_ext
    import mips_16_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int LOCAL_AW   = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_WIDTH-1:0]              mem_access_addr,
    input  logic                               mem_read_en,
    input  logic                               mem_write_en,
    input  logic [lane_count(DATA_WIDTH)-1:0]  mem_byte_en,
    input  logic [DATA_WIDTH-1:0]              mem_write_data,
    output logic [DATA_WIDTH-1:0]              mem_read_data,
    output logic                               mem_read_valid,
    output logic                               mem_stall,
    output logic                               mem_err,
    output logic                               ext_req,
    output logic                               ext_we,
    output logic [ADDR_WIDTH-1:0]              ext_addr,
    output logic [DATA_WIDTH-1:0]              ext_wdata,
    output logic [lane_count(DATA_WIDTH)-1:0]  ext_be,
    input  logic                               ext_ack,
    input  logic [DATA_WIDTH-1:0]              ext_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // The counter is cleared on entry, so the last permitted wait cycle
    // is the one where it reads TIMEOUT-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    ext_state_t            state;
    ext_state_t            state_next;
    logic [CW-1:0]         wait_cnt;

    logic                  is_local;
    logic                  do_read;
    logic                  local_we;
    logic                  local_re;
    logic                  ext_launch;
    logic                  ext_finish;
    logic                  ext_timeout;

    logic [DATA_WIDTH-1:0] bank_rdata;
    logic [DATA_WIDTH-1:0] ext_rdata_q;
    logic                  rd_from_ext;

    // Region decode and write-over-read priority.
    assign is_local = (mem_access_addr[ADDR_WIDTH-1:LOCAL_AW] == '0);
    assign do_read  = mem_read_en && !mem_write_en;

    // Only IDLE accepts new work; in EXT_DONE the held request is the one
    // just serviced and must not start another access.
    assign local_we   = (state == IDLE) && is_local && mem_write_en;
    assign local_re   = (state == IDLE) && is_local && do_read;
    assign ext_launch = (state == IDLE) && !is_local && (mem_write_en || do_read);

    // Ack takes precedence over a timeout landing in the same cycle.
    assign ext_timeout = (state == EXT_WAIT) && !ext_ack && (wait_cnt == CNT_LAST);
    assign ext_finish  = (state == EXT_WAIT) && (ext_ack || (wait_cnt == CNT_LAST));

    mem_bank_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOCAL_AW   (LOCAL_AW)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (local_we),
        .re    (local_re),
        .be    (mem_byte_en),
        .addr  (mem_access_addr[LOCAL_AW-1:0]),
        .wdata (mem_write_data),
        .rdata (bank_rdata)
    );

    // Both sources are registers; the select tracks which one completed last.
    assign mem_read_data = rd_from_ext ? ext_rdata_q : bank_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (ext_launch) begin
                    // Stall in the launch cycle itself so the pipeline holds.
                    mem_stall  = 1'b1;
                    state_next = EXT_WAIT;
                end
            end
            EXT_WAIT: begin
                mem_stall = 1'b1;
                if (ext_finish) begin
                    state_next = EXT_DONE;
                end
            end
            EXT_DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_req        <= 1'b0;
            ext_we         <= 1'b0;
            ext_addr       <= '0;
            ext_wdata      <= '0;
            ext_be         <= '0;
            wait_cnt       <= '0;
            mem_read_valid <= 1'b0;
            mem_err        <= 1'b0;
            ext_rdata_q    <= '0;
            rd_from_ext    <= 1'b0;
        end else begin
            mem_read_valid <= 1'b0;
            mem_err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (ext_launch) begin
                        ext_req   <= 1'b1;
                        ext_we    <= mem_write_en;
                        ext_addr  <= mem_access_addr;
                        ext_wdata <= mem_write_data;
                        ext_be    <= mem_byte_en;
                        wait_cnt  <= '0;
                    end
                    if (local_re) begin
                        mem_read_valid <= 1'b1;
                        rd_from_ext    <= 1'b0;
                    end
                end
                EXT_WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (ext_finish) begin
                        ext_req <= 1'b0;
                        mem_err <= ext_timeout;
                        if (!ext_we) begin
                            ext_rdata_q    <= ext_timeout ? ERR_DATA[DATA_WIDTH-1:0] : ext_rdata;
                            rd_from_ext    <= 1'b1;
                            mem_read_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ext.sv
`timescale 1ns/1ps
module tb_data_mem_ext;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int LAW = 8;
    localparam int TO  = 8;
    localparam int NB  = DW / 8;

    // ---------------- clock / reset / signals ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_access_addr;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [NB-1:0] mem_byte_en;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;
    logic          mem_read_valid;
    logic          mem_stall;
    logic          mem_err;
    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic [NB-1:0] ext_be;
    logic          ext_ack;
    logic [DW-1:0] ext_rdata;

    always #5 clk = ~clk;

    data_mem_ext #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LOCAL_AW   (LAW),
        .TIMEOUT    (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_access_addr (mem_access_addr),
        .mem_read_en     (mem_read_en),
        .mem_write_en    (mem_write_en),
        .mem_byte_en     (mem_byte_en),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data),
        .mem_read_valid  (mem_read_valid),
        .mem_stall       (mem_stall),
        .mem_err         (mem_err),
        .ext_req         (ext_req),
        .ext_we          (ext_we),
        .ext_addr        (ext_addr),
        .ext_wdata       (ext_wdata),
        .ext_be          (ext_be),
        .ext_ack         (ext_ack),
        .ext_rdata       (ext_rdata)
    );

    // ---------------- scoreboard / model state ----------------
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];          // read data expected, in completion order
    int            pending_err = 0;   // timeout pulses expected but not yet seen
    logic [DW-1:0] model_ram [0:(1<<LAW)-1];
    logic [AW-1:0] exp_ext_addr;
    logic          exp_ext_we;
    logic [DW-1:0] exp_ext_wdata;
    logic [NB-1:0] exp_ext_be;
    logic          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (mem_read_valid) begin
                check("read_valid_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("read_data", mem_read_data, exp_q.pop_front());
            end
            if (mem_err) begin
                check("mem_err_expected", pending_err > 0, 1);
                if (pending_err > 0) pending_err--;
            end
            if (ext_req) begin
                check("ext_addr", ext_addr, exp_ext_addr);
                check("ext_we", ext_we, exp_ext_we);
                check("ext_be", ext_be, exp_ext_be);
                if (exp_ext_we) check("ext_wdata", ext_wdata, exp_ext_wdata);
                check("stall_with_req", mem_stall, 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a rising edge.
    task automatic drop_inputs();
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_data"},  mem_read_data, 0);
        check({tag, "_read_valid"}, mem_read_valid, 0);
        check({tag, "_stall"},      mem_stall, 0);
        check({tag, "_err"},        mem_err, 0);
        check({tag, "_ext_req"},    ext_req, 0);
        check({tag, "_ext_we"},     ext_we, 0);
        check({tag, "_ext_addr"},   ext_addr, 0);
        check({tag, "_ext_wdata"},  ext_wdata, 0);
        check({tag, "_ext_be"},     ext_be, 0);
    endtask

    task automatic local_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        mem_access_addr = a;
        mem_write_data  = d;
        mem_byte_en     = be;
        mem_write_en    = 1'b1;
        mem_read_en     = 1'b0;
        model_ram[a[LAW-1:0]] = merge_bytes(model_ram[a[LAW-1:0]], d, be);
        @(negedge clk);
        check("local_write_stall", mem_stall, 0);
        @(posedge clk); #1;
        drop_inputs();
    endtask

    task automatic local_read(input logic [AW-1:0] a, input logic [DW-1:0] lit);
        mem_access_addr = a;
        mem_byte_en     = '0;
        mem_read_en     = 1'b1;
        mem_write_en    = 1'b0;
        exp_q.push_back(model_ram[a[LAW-1:0]]);
        @(negedge clk);
        check("local_read_stall", mem_stall, 0);
        @(posedge clk); #1;
        drop_inputs();
        @(negedge clk);
        check("local_read_valid_lit", mem_read_valid, 1);
        check("local_read_data_lit", mem_read_data, lit);
        check("local_read_stall_after", mem_stall, 0);
        @(posedge clk); #1;
    endtask

    // Launch one external access, optionally ack it on the ack_delay-th
    // cycle that ext_req is high, and check the request length and the
    // completion cycle.
    task automatic ext_access(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                              input logic [NB-1:0] be, input logic use_ack, input int ack_delay,
                              input logic [DW-1:0] rdata, input int exp_cycles,
                              input logic [DW-1:0] lit);
        int n;
        int guard;
        mem_access_addr = a;
        mem_write_data  = d;
        mem_byte_en     = be;
        mem_write_en    = we;
        mem_read_en     = !we;
        exp_ext_addr    = a;
        exp_ext_we      = we;
        exp_ext_wdata   = d;
        exp_ext_be      = be;
        if (!we) exp_q.push_back(use_ack ? rdata : {DW{1'b1}});
        if (!use_ack) pending_err++;
        @(negedge clk);
        check("launch_stall", mem_stall, 1);
        @(posedge clk); #1;
        n = 0;
        guard = 0;
        while (ext_req && guard < 40) begin
            n++;
            guard++;
            if (use_ack && n == ack_delay) begin
                ext_ack   = 1'b1;
                ext_rdata = rdata;
            end
            @(negedge clk);
            check("wait_stall", mem_stall, 1);
            @(posedge clk); #1;
            ext_ack = 1'b0;
        end
        check("ext_req_cycles", n, exp_cycles);
        // Completion cycle: request still held by the pipeline.
        @(negedge clk);
        check("done_stall", mem_stall, 0);
        check("done_err", mem_err, !use_ack);
        check("done_read_valid", mem_read_valid, !we);
        if (!we) check("done_read_data_lit", mem_read_data, lit);
        @(posedge clk); #1;
        drop_inputs();
        check("no_relaunch", ext_req, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst             = 1'b1;
        mem_access_addr = '0;
        mem_read_en     = 1'b0;
        mem_write_en    = 1'b0;
        mem_byte_en     = '0;
        mem_write_data  = '0;
        ext_ack         = 1'b0;
        ext_rdata       = '0;
        exp_ext_addr    = '0;
        exp_ext_we      = 1'b0;
        exp_ext_wdata   = '0;
        exp_ext_be      = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Local write then read the next cycle, then check the hold.
        local_write(16'h0010, 16'hBEEF, 2'b11);
        local_read (16'h0010, 16'hBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        check("read_data_hold", mem_read_data, 16'hBEEF);
        check("no_spurious_valid", mem_read_valid, 0);
        @(posedge clk); #1;

        // Low byte lane only.
        local_write(16'h0010, 16'h12AB, 2'b01);
        local_read (16'h0010, 16'hBEAB);

        // Highest local word, upper lane then lower lane.
        local_write(16'h00FF, 16'hC3AA, 2'b10);
        local_write(16'h00FF, 16'h5534, 2'b01);
        local_read (16'h00FF, 16'hC334);

        // First external word, ack after 4 cycles.
        ext_access(16'h0100, 1'b0, 16'h0000, 2'b11, 1'b1, 4, 16'h5A5A, 4, 16'h5A5A);

        // External write with no ack: times out after TO wait cycles.
        ext_access(16'h8000, 1'b1, 16'h1234, 2'b11, 1'b0, 0, 16'h0000, TO, 16'h0000);

        // External read timeout returns all ones; back-to-back with the next.
        ext_access(16'h0200, 1'b0, 16'h0000, 2'b11, 1'b0, 0, 16'h0000, TO, 16'hFFFF);
        ext_access(16'hFFFF, 1'b0, 16'h0000, 2'b00, 1'b1, 1, 16'h1357, 1, 16'h1357);

        // Ack on the very last allowed wait cycle.
        ext_access(16'h4000, 1'b0, 16'h0000, 2'b11, 1'b1, TO, 16'h2468, TO, 16'h2468);

        // External partial write, acked on cycle 3.
        ext_access(16'h0100, 1'b1, 16'hA0B0, 2'b10, 1'b1, 3, 16'h0000, 3, 16'h0000);

        // Simultaneous read and write: treated as a write.
        mem_access_addr = 16'h0020;
        mem_write_data  = 16'h00FF;
        mem_byte_en     = 2'b11;
        mem_write_en    = 1'b1;
        mem_read_en     = 1'b1;
        model_ram[8'h20] = 16'h00FF;
        @(negedge clk);
        check("rw_stall", mem_stall, 0);
        @(posedge clk); #1;
        drop_inputs();
        @(negedge clk);
        check("rw_no_valid", mem_read_valid, 0);
        @(posedge clk); #1;
        local_read(16'h0020, 16'h00FF);

        // Reset in the second wait cycle, then a late ack.
        mem_access_addr = 16'h0100;
        mem_byte_en     = 2'b11;
        mem_read_en     = 1'b1;
        mem_write_en    = 1'b0;
        exp_ext_addr    = 16'h0100;
        exp_ext_we      = 1'b0;
        exp_ext_be      = 2'b11;
        @(posedge clk); #1;
        check("rst_test_req_wait1", ext_req, 1);
        @(posedge clk); #1;
        check("rst_test_req_wait2", ext_req, 1);
        rst = 1'b1;
        drop_inputs();
        @(posedge clk); #1;
        rst       = 1'b0;
        ext_ack   = 1'b1;
        ext_rdata = 16'h7777;
        @(negedge clk);
        check_all_zero("after_rst");
        @(posedge clk); #1;
        ext_ack = 1'b0;
        @(negedge clk);
        check("late_ack_req", ext_req, 0);
        check("late_ack_valid", mem_read_valid, 0);
        check("late_ack_stall", mem_stall, 0);
        @(posedge clk); #1;

        // RAM survives reset.
        local_read(16'h0010, 16'hBEAB);
        local_read(16'h0020, 16'h00FF);

        repeat (3) @(posedge clk);
        #1;
        check("leftover_reads", exp_q.size(), 0);
        check("leftover_errs", pending_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_mem_ext.md
Name: data_mem_ext

Overview:
- Parametrised next-generation MIPS16 data memory: a local synchronous RAM with byte-lane writes and a registered read port.
- Accesses above the local range are forwarded to an external memory port through a req/ack handshake.
- The pipeline is stalled while an external access is outstanding; a timeout flags a bus error.
- Sits in the MEM stage, replacing the combinational-read RAM.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of 8
ADDR_WIDTH, 16, width of the word address from the pipeline
LOCAL_AW, 8, local RAM address bits; local depth = 2**LOCAL_AW words
TIMEOUT, 255, maximum cycles to wait for ext_ack before flagging an error; must be >= 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_access_addr  in  ADDR_WIDTH  word address
mem_read_en  in  1  read request
mem_write_en  in  1  write request
mem_byte_en  in  DATA_WIDTH/8  byte-lane write enables
mem_write_data  in  DATA_WIDTH  write data
mem_read_data  out  DATA_WIDTH  read data; meaningful when mem_read_valid = 1
mem_read_valid  out  1  one-cycle pulse, read data valid
mem_stall  out  1  stall the pipeline; the request must be held stable while high
mem_err  out  1  one-cycle pulse on external timeout
ext_req  out  1  external request
ext_we  out  1  external write
ext_addr  out  ADDR_WIDTH  external address
ext_wdata  out  DATA_WIDTH  external write data
ext_be  out  DATA_WIDTH/8  external byte enables
ext_ack  in  1  external completion pulse
ext_rdata  in  DATA_WIDTH  external read data; valid with ext_ack

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0 and FSM = IDLE. RAM contents are not cleared. A reset during an external access drops ext_req on the next edge and abandons the transaction; a late ext_ack is then ignored.
- Region decode: local when mem_access_addr[ADDR_WIDTH-1:LOCAL_AW] == 0, otherwise external.
- Write/read conflict: write has priority; a request with both mem_write_en and mem_read_en set is treated as a write only, and mem_read_valid does not pulse.
- Local write: byte lane i is written at posedge when mem_write_en and mem_byte_en[i] are set. No stall.
- Local read: latency 1. mem_read_data is registered and mem_read_valid pulses in the cycle after mem_read_en. No stall.
- Write-then-read, same address: a read in the cycle after a write returns the new data.
- Byte enables on read: ignored.
- mem_read_data between reads: holds its last value when no read completes.
- FSM states: IDLE, EXT_WAIT, EXT_DONE.
- IDLE → EXT_WAIT: on a valid external request (read or write).
  - Latch ext_addr, ext_we, ext_wdata and ext_be; assert ext_req next cycle.
  - mem_stall is asserted combinationally in the same cycle as the request, so the pipeline holds.
- EXT_WAIT:
  - ext_req and mem_stall stay high; the timeout counter increments each cycle.
  - On ext_ack: drop ext_req, capture ext_rdata (reads only), go to EXT_DONE.
  - If the counter reaches TIMEOUT without ack: drop ext_req, pulse mem_err, go to EXT_DONE. mem_read_data is then all ones for a read.
- EXT_DONE:
  - mem_stall = 0. mem_read_valid pulses if the transaction was a read.
  - Go to IDLE. The held request is consumed this cycle and must not re-launch.
- ext_ack outside EXT_WAIT: ignored.
- Timeout counter: width $clog2(TIMEOUT+1); cleared on entry to EXT_WAIT.
- Back-to-back external accesses: minimum 3 cycles each (IDLE, EXT_WAIT, EXT_DONE).

Decomposition:
- Package mips_16_mem_pkg holds:
  - the state enum typedef ext_state_t {IDLE, EXT_WAIT, EXT_DONE};
  - the all-ones error-data constant;
  - a localparam function for byte-lane count.
- One sub-module, mem_bank_be: the byte-enabled single-port RAM with registered read, parametrised by DATA_WIDTH and LOCAL_AW.
- FSM and decode stay in the top module.

Test Plan:
- Local write, then read:
  - Write 0xBEEF to addr 0x0010 with mem_byte_en = 2'b11.
  - Read 0x0010 next cycle → mem_read_data = 0xBEEF with valid one cycle later; mem_stall stays 0.
- Byte lanes: write 0x12AB with mem_byte_en = 2'b01 over 0xBEEF → read returns 0xBEAB.
- External read:
  - Read 0x0100; bench returns ext_ack after 4 cycles with ext_rdata = 0x5A5A.
  - Required: ext_req high for exactly 4 cycles, mem_stall high through ext_ack, mem_read_valid pulses with 0x5A5A.
- Timeout:
  - TIMEOUT = 8, external write to 0x8000, no ack.
  - Required: mem_err pulses once, ext_req drops after 8 wait cycles, mem_stall then releases.
- Simultaneous read and write: both enables set at 0x0020 with data 0x00FF → RAM updated, no mem_read_valid pulse.
- Reset mid-access:
  - Assert rst in the second EXT_WAIT cycle, then ack one cycle later.
  - Required: all outputs 0 after the edge, ack ignored, RAM contents preserved.
